vx_writeback_unit: RTL and testbench



---
 rtl/vx_writeback_unit_pkg.sv | 26 ++
 rtl/vx_writeback_unit.sv | 137 +++++++++++++
 tb/tb_vx_writeback_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_writeback_unit_pkg.sv
// Shared configuration for the cache writeback unit: FSM state encoding and
// helpers that derive the line-select geometry from the cache parameters.
package vx_writeback_unit_pkg;

  // Writeback FSM encoding, kept as plain constants so older code can compare
  // against them directly.
  localparam int         WB_STATE_BITS = 2;
  localparam logic [1:0] WB_IDLE       = 2'd0;
  localparam logic [1:0] WB_READ       = 2'd1;
  localparam logic [1:0] WB_SEND       = 2'd2;
  localparam logic [1:0] WB_CLEAR      = 2'd3;

  // Number of lines held by one bank of the data store.
  function automatic int wb_lines_per_bank(input int cache_size,
                                           input int line_size,
                                           input int num_banks);
    return cache_size / (line_size * num_banks);
  endfunction

  // Width of a line index; never below one bit so a single-line bank still
  // has a legal vector type.
  function automatic int wb_line_select_bits(input int lines_per_bank);
    return (lines_per_bank > 1) ? $clog2(lines_per_bank) : 1;
  endfunction

endpackage

// File: rtl/vx_writeback_unit.sv
// Cache writeback unit. Writes a single evicted line back to memory, or walks
// every line of the bank on a flush, writing the dirty bytes of each valid line
// and clearing the dirty bits afterwards. The data store has one cycle of read
// latency: the line index is registered on acceptance and the store output is
// captured in READ.
module vx_writeback_unit
  import vx_writeback_unit_pkg::*;
#(
  parameter int  CACHE_SIZE       = 16384,
  parameter int  CACHE_LINE_SIZE  = 64,
  parameter int  NUM_BANKS        = 1,
  parameter int  WORD_SIZE        = 4,
  parameter int  TAG_WIDTH        = 20,
  localparam int LINES_PER_BANK   = wb_lines_per_bank(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS),
  localparam int LINE_SELECT_BITS = wb_line_select_bits(LINES_PER_BANK)
) (
  input  logic                              clk,
  input  logic                              reset,

  input  logic                              evict_valid,
  input  logic [LINE_SELECT_BITS-1:0]       evict_line,
  input  logic [TAG_WIDTH-1:0]              evict_tag,
  output logic                              evict_ready,

  input  logic                              flush_start,
  output logic                              flush_done,
  output logic                              busy,

  output logic [LINE_SELECT_BITS-1:0]       ds_read_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0]      ds_read_data,
  input  logic [CACHE_LINE_SIZE-1:0]        ds_read_dirtyb,
  input  logic [TAG_WIDTH-1:0]              ts_read_tag,
  input  logic                              ts_read_valid,

  output logic                              ds_clear_valid,
  output logic [LINE_SELECT_BITS-1:0]       ds_clear_addr,

  output logic                              mem_req_valid,
  output logic [TAG_WIDTH+LINE_SELECT_BITS-1:0] mem_req_addr,
  output logic [CACHE_LINE_SIZE*8-1:0]      mem_req_data,
  output logic [CACHE_LINE_SIZE-1:0]        mem_req_byteen,
  input  logic                              mem_req_ready
);

  localparam logic [LINE_SELECT_BITS-1:0] LAST_LINE = LINE_SELECT_BITS'(LINES_PER_BANK - 1);

  // A line must hold a whole number of words; anything else is a bad build.
  if ((CACHE_LINE_SIZE % WORD_SIZE) != 0) begin : g_bad_word_size
    $error("vx_writeback_unit: CACHE_LINE_SIZE must be a multiple of WORD_SIZE");
  end

  logic [WB_STATE_BITS-1:0]      state;
  logic [WB_STATE_BITS-1:0]      state_next;
  logic                          flush_mode;
  logic [LINE_SELECT_BITS-1:0]   line_reg;
  logic [TAG_WIDTH-1:0]          tag_reg;
  logic [CACHE_LINE_SIZE*8-1:0]  data_reg;
  logic [CACHE_LINE_SIZE-1:0]    mask_reg;
  logic                          writable;
  logic                          last_line;
  logic                          accept_flush;
  logic                          accept_evict;

  // Decode request acceptance, the writable test and the next FSM state.
  always_comb begin
    accept_flush = (state == WB_IDLE) && flush_start;
    accept_evict = (state == WB_IDLE) && !flush_start && evict_valid;
    writable     = (ds_read_dirtyb != '0) && (!flush_mode || ts_read_valid);
    last_line    = (line_reg == LAST_LINE);
    state_next   = state;
    case (state)
      WB_IDLE:  if (accept_flush || accept_evict) state_next = WB_READ;
      WB_READ:  state_next = writable ? WB_SEND : WB_CLEAR;
      WB_SEND:  if (mem_req_ready) state_next = WB_CLEAR;
      WB_CLEAR: state_next = (flush_mode && !last_line) ? WB_READ : WB_IDLE;
      default:  state_next = WB_IDLE;
    endcase
  end

  // FSM state register; reset abandons whatever line was in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Line index, mode and tag: loaded on acceptance, stepped after each flush clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_mode <= 1'b0;
      line_reg   <= '0;
      tag_reg    <= '0;
    end else begin
      if (accept_flush) begin
        flush_mode <= 1'b1;
        line_reg   <= '0;
      end else if (accept_evict) begin
        flush_mode <= 1'b0;
        line_reg   <= evict_line;
        tag_reg    <= evict_tag;
      end else if (state == WB_READ && flush_mode) begin
        tag_reg    <= ts_read_tag;
      end else if (state == WB_CLEAR && flush_mode && !last_line) begin
        line_reg   <= line_reg + LINE_SELECT_BITS'(1);
      end
    end
  end

  // Capture the store output one cycle after the index was presented; held
  // unchanged through SEND so the memory request stays stable while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg <= '0;
      mask_reg <= '0;
    end else if (state == WB_READ) begin
      data_reg <= ds_read_data;
      mask_reg <= ds_read_dirtyb;
    end
  end

  // Outputs come from registers or the state alone, never from mem_req_ready.
  always_comb begin
    evict_ready    = (state == WB_IDLE);
    busy           = (state != WB_IDLE);
    ds_read_addr   = line_reg;
    ds_clear_valid = (state == WB_CLEAR);
    ds_clear_addr  = line_reg;
    flush_done     = (state == WB_CLEAR) && flush_mode && last_line;
    mem_req_valid  = (state == WB_SEND);
    mem_req_addr   = {tag_reg, line_reg};
    mem_req_data   = data_reg;
    mem_req_byteen = mask_reg;
  end

endmodule

// File: tb/tb_vx_writeback_unit.sv
// Self-checking bench for vx_writeback_unit on a four-line configuration. The
// data/tag store is modelled as arrays; expected memory writes, clears, flush
// pulses and cycle counts are predicted from the store contents before each
// operation and compared with what the monitor logs.
module tb_vx_writeback_unit;

  localparam int CS     = 64;
  localparam int LS     = 16;
  localparam int NB     = 1;
  localparam int WS     = 4;
  localparam int TW     = 20;
  localparam int NLINES = 4;
  localparam int LSB    = 2;
  localparam int DW     = LS * 8;
  localparam int AW     = TW + LSB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic evict_valid = 1'b0;
  logic [LSB-1:0] evict_line = '0;
  logic [TW-1:0]  evict_tag = '0;
  logic evict_ready;
  logic flush_start = 1'b0;
  logic flush_done;
  logic busy;
  logic [LSB-1:0] ds_read_addr;
  logic [DW-1:0]  ds_read_data;
  logic [LS-1:0]  ds_read_dirtyb;
  logic [TW-1:0]  ts_read_tag;
  logic           ts_read_valid;
  logic           ds_clear_valid;
  logic [LSB-1:0] ds_clear_addr;
  logic           mem_req_valid;
  logic [AW-1:0]  mem_req_addr;
  logic [DW-1:0]  mem_req_data;
  logic [LS-1:0]  mem_req_byteen;
  logic           mem_req_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  // Store contents seen by the unit
  logic [DW-1:0] st_data  [NLINES];
  logic [LS-1:0] st_mask  [NLINES];
  logic [TW-1:0] st_tag   [NLINES];
  logic          st_valid [NLINES];

  // Observed activity
  logic [AW-1:0]  req_addr_log[$];
  logic [DW-1:0]  req_data_log[$];
  logic [LS-1:0]  req_mask_log[$];
  logic [LSB-1:0] clr_log[$];
  int done_cnt = 0;

  // Predicted activity
  logic [AW-1:0]  exp_addr[$];
  logic [DW-1:0]  exp_data[$];
  logic [LS-1:0]  exp_mask[$];
  logic [LSB-1:0] exp_clr[$];
  int exp_done;
  int exp_cycles;

  int stall_cfg = 0;
  int stall_left = 0;
  bit send_pending = 1'b0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  logic [LS-1:0] held_mask;

  vx_writeback_unit #(
    .CACHE_SIZE(CS), .CACHE_LINE_SIZE(LS), .NUM_BANKS(NB),
    .WORD_SIZE(WS), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .evict_valid(evict_valid), .evict_line(evict_line), .evict_tag(evict_tag),
    .evict_ready(evict_ready),
    .flush_start(flush_start), .flush_done(flush_done), .busy(busy),
    .ds_read_addr(ds_read_addr), .ds_read_data(ds_read_data),
    .ds_read_dirtyb(ds_read_dirtyb), .ts_read_tag(ts_read_tag),
    .ts_read_valid(ts_read_valid),
    .ds_clear_valid(ds_clear_valid), .ds_clear_addr(ds_clear_addr),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen),
    .mem_req_ready(mem_req_ready)
  );

  always #5 clk = ~clk;

  assign ds_read_data   = st_data[ds_read_addr];
  assign ds_read_dirtyb = st_mask[ds_read_addr];
  assign ts_read_tag    = st_tag[ds_read_addr];
  assign ts_read_valid  = st_valid[ds_read_addr];

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Monitor: logs clears, flush pulses and handshakes, models the memory's
  // ready stalls, and checks the request is held steady while stalled.
  always @(negedge clk) begin
    if (reset) begin
      if (ds_clear_valid) begin
        clr_log.push_back(ds_clear_addr);
        st_mask[ds_clear_addr] = '0;
      end
      if (flush_done) done_cnt++;
      if (mem_req_valid) begin
        if (send_pending) begin
          checkOutput("stall_addr_stable", mem_req_addr, held_addr);
          checkOutput("stall_data_stable", mem_req_data, held_data);
          checkOutput("stall_mask_stable", mem_req_byteen, held_mask);
        end
        held_addr = mem_req_addr;
        held_data = mem_req_data;
        held_mask = mem_req_byteen;
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
          send_pending = 1'b1;
        end else begin
          mem_req_ready = 1'b1;
          send_pending = 1'b0;
          req_addr_log.push_back(mem_req_addr);
          req_data_log.push_back(mem_req_data);
          req_mask_log.push_back(mem_req_byteen);
        end
      end else begin
        mem_req_ready = 1'b1;
        send_pending = 1'b0;
        stall_left = stall_cfg;
      end
    end else begin
      send_pending = 1'b0;
      stall_left = stall_cfg;
    end
  end

  task automatic clear_logs();
    req_addr_log.delete();
    req_data_log.delete();
    req_mask_log.delete();
    clr_log.delete();
  endtask

  // Predict the outcome of an operation from the current store contents:
  // valid dirty lines (any dirty line for an evict) are written with their
  // dirty mask, every visited line is cleared, a flush pulses done once.
  task automatic build_expect(input bit is_flush, input logic [LSB-1:0] line,
                              input logic [TW-1:0] tag);
    exp_addr.delete();
    exp_data.delete();
    exp_mask.delete();
    exp_clr.delete();
    exp_done = 0;
    exp_cycles = 1;
    if (is_flush) begin
      for (int i = 0; i < NLINES; i++) begin
        if (st_valid[i] && st_mask[i] != '0) begin
          exp_addr.push_back({st_tag[i], LSB'(i)});
          exp_data.push_back(st_data[i]);
          exp_mask.push_back(st_mask[i]);
          exp_cycles += 3 + stall_cfg;
        end else begin
          exp_cycles += 2;
        end
        exp_clr.push_back(LSB'(i));
      end
      exp_done = 1;
    end else begin
      if (st_mask[line] != '0) begin
        exp_addr.push_back({tag, line});
        exp_data.push_back(st_data[line]);
        exp_mask.push_back(st_mask[line]);
        exp_cycles += 3 + stall_cfg;
      end else begin
        exp_cycles += 2;
      end
      exp_clr.push_back(line);
    end
  endtask

  // Issue one operation from IDLE, wait (bounded) for completion, compare.
  // A non-zero poke_at pulses flush_start on that cycle of the operation.
  task automatic applyStimulus(input bit do_flush, input bit do_evict,
                               input logic [LSB-1:0] line, input logic [TW-1:0] tag,
                               input int poke_at, input string name);
    int cycles;
    int done0;
    build_expect(do_flush, line, tag);
    clear_logs();
    done0 = done_cnt;
    checkOutput({name, "_ready"}, evict_ready, 1'b1);
    flush_start = do_flush;
    evict_valid = do_evict;
    evict_line  = line;
    evict_tag   = tag;
    @(posedge clk); #1;
    flush_start = 1'b0;
    evict_valid = 1'b0;
    cycles = 1;
    while (busy && cycles < 300) begin
      flush_start = (cycles == poke_at);
      @(posedge clk); #1;
      cycles++;
    end
    flush_start = 1'b0;
    checkOutput({name, "_idle"}, busy, 1'b0);
    checkOutput({name, "_cycles"}, cycles, exp_cycles);
    checkOutput({name, "_req_count"}, req_addr_log.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < req_addr_log.size(); i++) begin
      checkOutput({name, "_req_addr"}, req_addr_log[i], exp_addr[i]);
      checkOutput({name, "_req_data"}, req_data_log[i], exp_data[i]);
      checkOutput({name, "_req_byteen"}, req_mask_log[i], exp_mask[i]);
    end
    checkOutput({name, "_clr_count"}, clr_log.size(), exp_clr.size());
    for (int i = 0; i < exp_clr.size() && i < clr_log.size(); i++) begin
      checkOutput({name, "_clr_addr"}, clr_log[i], exp_clr[i]);
    end
    checkOutput({name, "_done_count"}, done_cnt - done0, exp_done);
  endtask

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < NLINES; i++) begin
      st_data[i]  = {$urandom, $urandom, $urandom, $urandom};
      st_mask[i]  = '0;
      st_tag[i]   = TW'($urandom);
      st_valid[i] = 1'b1;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_evict_ready", evict_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_mem_req_valid", mem_req_valid, 1'b0);
    checkOutput("rst_clear_valid", ds_clear_valid, 1'b0);
    checkOutput("rst_flush_done", flush_done, 1'b0);
    checkOutput("rst_mem_req_addr", mem_req_addr, '0);
    checkOutput("rst_mem_req_data", mem_req_data, '0);
    checkOutput("rst_mem_req_byteen", mem_req_byteen, '0);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // Dirty evict with memory always ready
    st_mask[3] = 16'h000F;
    stall_cfg = 0;
    applyStimulus(1'b0, 1'b1, 2'd3, 20'h12, 0, "evict_dirty");
    checkOutput("evict_dirty_addr_value", (req_addr_log.size() > 0) ? req_addr_log[0] : '0,
                22'h00004B);

    // Clean evict
    st_mask[1] = '0;
    applyStimulus(1'b0, 1'b1, 2'd1, 20'hABCDE, 0, "evict_clean");

    // Dirty evict with memory stalling five cycles
    st_mask[2] = 16'hA5A5;
    stall_cfg = 5;
    applyStimulus(1'b0, 1'b1, 2'd2, 20'h0F00D, 0, "evict_stall");
    stall_cfg = 0;

    // Flush and evict together; lines 1 and 3 dirty
    st_mask[0] = '0;
    st_mask[1] = 16'h0300;
    st_mask[2] = '0;
    st_mask[3] = 16'hFFFF;
    for (int i = 0; i < NLINES; i++) st_valid[i] = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd2, 20'h55555, 0, "flush_prio");

    // flush_start while busy is ignored
    for (int i = 0; i < NLINES; i++) st_mask[i] = '0;
    applyStimulus(1'b1, 1'b0, 2'd0, 20'h0, 3, "flush_busy");
    repeat (4) @(posedge clk);
    #1;
    checkOutput("flush_busy_no_restart", busy, 1'b0);

    // Reset during SEND
    st_mask[2] = 16'h00F0;
    stall_cfg = 10;
    clear_logs();
    evict_valid = 1'b1;
    evict_line  = 2'd2;
    evict_tag   = 20'h77777;
    @(posedge clk); #1;
    evict_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rst_send_reached", mem_req_valid, 1'b1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checkOutput("rst_send_valid_drop", mem_req_valid, 1'b0);
    checkOutput("rst_send_busy", busy, 1'b0);
    checkOutput("rst_send_ready", evict_ready, 1'b1);
    checkOutput("rst_send_clear", ds_clear_valid, 1'b0);
    checkOutput("rst_send_addr", mem_req_addr, '0);
    @(posedge clk); #2;
    reset = 1'b1;
    stall_cfg = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_send_no_req", req_addr_log.size(), 0);
    checkOutput("rst_send_no_clr", clr_log.size(), 0);
    checkOutput("rst_send_idle", busy, 1'b0);

    // Randomized operations
    for (int it = 0; it < 30; it++) begin
      int op;
      for (int i = 0; i < NLINES; i++) begin
        st_data[i]  = {$urandom, $urandom, $urandom, $urandom};
        st_mask[i]  = ($urandom_range(0, 1) == 1) ? LS'($urandom) : '0;
        st_tag[i]   = TW'($urandom);
        st_valid[i] = ($urandom_range(0, 3) != 0);
      end
      stall_cfg = $urandom_range(0, 3);
      op = $urandom_range(0, 2);
      applyStimulus(op != 0, op != 1, LSB'($urandom_range(0, NLINES - 1)),
                    TW'($urandom), 0, "random");
    end
    stall_cfg = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
